// File: rtl/arith_alu_pkg.sv
// Shared op codes, FSM state encoding and the signed-overflow helper for the
// sequential arithmetic ALU.
package arith_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NEG = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Two's-complement overflow: both addends agree in sign and the sum disagrees.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/arith_alu_seq_if.sv
// Command/result handshake bundle of arith_alu_seq. The slave modport is the
// ALU; the master modport is the operand source plus the result consumer.
interface arith_alu_seq_if #(parameter int WIDTH = 4);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, a, b, c_in, op, out_ready,
    input  in_ready, out_valid, out, c_out, zero, ovf, err
  );

  modport slave (
    input  in_valid, a, b, c_in, op, out_ready,
    output in_ready, out_valid, out, c_out, zero, ovf, err
  );

endinterface

// File: rtl/arith_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, counter from
// WIDTH-1 down to 0; o_product is valid in the cycle o_done is high.
module arith_alu_mul #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_active,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Operand capture at start, then shift/accumulate while the FSM is in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH - 1);
    end else if (i_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_done    = i_active && (r_cnt == '0);
  assign o_product = w_acc_next;

endmodule

// File: rtl/arith_alu_seq.sv
// Registered WIDTH-bit arithmetic unit with valid/ready on both sides and a
// one-entry result register. Define ARITH_ALU_MUL_EN to enable the multi-cycle multiply.
module arith_alu_seq #(parameter int WIDTH = 4) (
  input  logic            clk,
  input  logic            rst_n,
  arith_alu_seq_if.slave  bus
);

  import arith_alu_pkg::*;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_start_mul;
  logic               w_load_single;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_c;
  logic               w_res_v;
  logic               w_res_e;
  logic [WIDTH-1:0]   r_out;
  logic               r_c_out;
  logic               r_ovf;
  logic               r_err;
  logic               r_zero;
  logic               r_out_valid;

  assign w_in_ready    = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_load_single = w_accept && !w_start_mul;

`ifdef ARITH_ALU_MUL_EN
  assign w_start_mul = w_accept && (bus.op == OP_MUL);

  arith_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start_mul),
    .i_active  (r_state == ST_MUL),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
`else
  assign w_start_mul = 1'b0;
  assign w_mul_done  = (r_state == ST_MUL);
  assign w_product   = '0;
`endif

  // Map each op onto one WIDTH+1-bit addition a' + b' + cin.
  always_comb begin
    w_opa = bus.a;
    w_opb = bus.b;
    w_cin = 1'b0;
    case (bus.op)
      OP_ADD: w_cin = 1'b0;
      OP_ADC: w_cin = bus.c_in;
      OP_SUB: begin w_opb = ~bus.b; w_cin = 1'b1;     end
      OP_SBC: begin w_opb = ~bus.b; w_cin = bus.c_in; end
      OP_INC: begin w_opb = '0;     w_cin = 1'b1;     end
      OP_DEC: begin w_opb = '1;     w_cin = 1'b0;     end
      OP_NEG: begin w_opa = ~bus.a; w_opb = '0; w_cin = 1'b1; end
      default: w_cin = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};

  // Single-cycle result and flags; op 110 only lands here when the multiplier is absent.
  always_comb begin
    w_res   = w_sum[WIDTH-1:0];
    w_res_c = w_sum[WIDTH];
    w_res_v = add_ovf(w_opa[WIDTH-1], w_opb[WIDTH-1], w_sum[WIDTH-1]);
    w_res_e = 1'b0;
    if (bus.op == OP_MUL) begin
      w_res   = '0;
      w_res_c = 1'b0;
      w_res_v = 1'b0;
`ifdef ARITH_ALU_MUL_EN
      w_res_e = 1'b0;
`else
      w_res_e = 1'b1;
`endif
    end else begin
      w_res_e = 1'b0;
    end
  end

  // Next-state logic: IDLE -> MUL on an accepted multiply, back on the last bit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mul) w_state_next = ST_MUL;
        else             w_state_next = ST_IDLE;
      end
      ST_MUL: begin
        if (w_mul_done) w_state_next = ST_IDLE;
        else            w_state_next = ST_MUL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // One-entry result register; a load in the same edge as a pop keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (w_load_single) begin
      r_out       <= w_res;
      r_c_out     <= w_res_c;
      r_ovf       <= w_res_v;
      r_err       <= w_res_e;
      r_zero      <= (w_res == '0);
      r_out_valid <= 1'b1;
    end else if (w_mul_done) begin
      r_out       <= w_product[WIDTH-1:0];
      r_c_out     <= |w_product[2*WIDTH-1:WIDTH];
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_zero      <= (w_product[WIDTH-1:0] == '0);
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_arith_alu_seq.sv
// Bench for arith_alu_seq: directed corner cases, backpressure, multiply timing,
// then an exhaustive op/operand sweep plus random commands under random out_ready.
module tb_arith_alu_seq;

  import arith_alu_pkg::*;

  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         v;
    logic         e;
    logic         z;
  } res_t;

  logic clk;
  logic rst_n;
  logic rand_rdy;
  int   n_err;
  int   n_chk;
  int   n_extra;
  int   n_sent;
  int   n_got;
  res_t got_q[$];
  res_t exp_q[$];

  arith_alu_seq_if #(.WIDTH(W)) bus ();

  arith_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t observe();
    res_t x;
    x.out = bus.out;
    x.c   = bus.c_out;
    x.v   = bus.ovf;
    x.e   = bus.err;
    x.z   = bus.zero;
    return x;
  endfunction

  // Consumer: record every result handed over at a rising edge.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(observe());
  end

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input logic [2:0] op, input int a, input int b, input int ci);
    res_t x;
    int   sa, sb, r, s, o;
    logic c;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    r = 0; s = 0; c = 1'b0;
    x = '0;
    case (op)
      OP_ADD: begin r = a + b;          s = sa + sb;          c = (r >= M); end
      OP_ADC: begin r = a + b + ci;     s = sa + sb + ci;     c = (r >= M); end
      OP_SUB: begin r = a - b;          s = sa - sb;          c = (r >= 0); end
      OP_SBC: begin r = a - b - 1 + ci; s = sa - sb - 1 + ci; c = (r >= 0); end
      OP_INC: begin r = a + 1;          s = sa + 1;           c = (r >= M); end
      OP_DEC: begin r = a - 1;          s = sa - 1;           c = (r >= 0); end
      OP_NEG: begin r = -a;             s = -sa;              c = (a == 0); end
      default: begin
`ifdef ARITH_ALU_MUL_EN
        r = a * b; c = (r >= M);
`else
        r = 0; c = 1'b0; x.e = 1'b1;
`endif
      end
    endcase
    o     = ((r % M) + M) % M;
    x.out = W'(o);
    x.c   = c;
    x.v   = (op != OP_MUL) && ((s > M/2 - 1) || (s < -(M/2)));
    x.z   = (o == 0);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Present a command, wait for acceptance, then scramble the operand inputs.
  task automatic send(input logic [2:0] op, input int a, input int b, input int ci);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.c_in     = ci[0];
    while (!bus.in_ready && waited < 200) begin
      step();
      waited++;
    end
    chk("accept_timeout", 32'(waited >= 200), 32'(0));
    @(posedge clk);
    step();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.c_in     = 1'($urandom);
    n_sent++;
  endtask

  task automatic expect_now(input string tag, input res_t e);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
    chk(tag, 32'(observe()), 32'(e));
  endtask

  task automatic do1(input string tag, input logic [2:0] op, input int a, input int b, input int ci);
    send(op, a, b, ci);
    expect_now(tag, model(op, a, b, ci));
  endtask

  task automatic drain_cmp();
    res_t g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_got++;
      if (exp_q.size() == 0) n_extra++;
      else chk("sb", 32'(g), 32'(exp_q.pop_front()));
    end
  endtask

`ifdef ARITH_ALU_MUL_EN
  task automatic mul_check(input string tag, input int a, input int b);
    send(OP_MUL, a, b, 0);
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(bus.in_ready), 32'(0));
      chk({tag, "_pending"}, 32'(bus.out_valid), 32'(0));
      step();
    end
    expect_now(tag, model(OP_MUL, a, b, 0));
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'(1));
  endtask
`endif

  initial begin
    n_err = 0; n_chk = 0; n_extra = 0; n_sent = 0; n_got = 0;
    rand_rdy      = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.op        = OP_ADD;
    bus.out_ready = 1'b1;
    repeat (3) step();

    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out",       32'(bus.out),       32'(0));
    chk("rst_zero",      32'(bus.zero),      32'(1));
    chk("rst_c_out",     32'(bus.c_out),     32'(0));
    chk("rst_ovf",       32'(bus.ovf),       32'(0));
    chk("rst_err",       32'(bus.err),       32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
    rst_n = 1'b1;
    step();

    do1("add_7_9",  OP_ADD, 7, 9, 0);
    step();
    chk("add_7_9_consumed", 32'(bus.out_valid), 32'(0));
    do1("sub_3_5",  OP_SUB, 3, 5, 0);
    do1("sbc_5_3",  OP_SBC, 5, 3, 0);
    do1("add_7_1",  OP_ADD, 7, 1, 0);
    do1("neg_8",    OP_NEG, 8, 0, 0);
    do1("neg_0",    OP_NEG, 0, 0, 0);
    do1("dec_0",    OP_DEC, 0, 0, 0);
    do1("adc_15_0", OP_ADC, 15, 0, 1);
    do1("inc_7",    OP_INC, 7, 0, 0);
    step();

    // Backpressure: first result must be held until the consumer is ready.
    got_q.delete();
    bus.out_ready = 1'b0;
    send(OP_ADD, 1, 1, 0);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = W'(2); bus.b = W'(2); bus.c_in = 1'b0;
    repeat (3) begin
      step();
      chk("bp_in_ready", 32'(bus.in_ready),  32'(0));
      chk("bp_hold_out", 32'(bus.out),       32'(2));
      chk("bp_valid",    32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("bp_second_out",   32'(bus.out),       32'(4));
    chk("bp_second_valid", 32'(bus.out_valid), 32'(1));
    step();
    chk("bp_drained", 32'(bus.out_valid), 32'(0));
    chk("bp_count",   32'(got_q.size()),  32'(2));
    if (got_q.size() == 2) begin
      chk("bp_first_pop",  32'(got_q[0].out), 32'(2));
      chk("bp_second_pop", 32'(got_q[1].out), 32'(4));
    end

`ifdef ARITH_ALU_MUL_EN
    mul_check("mul_7_6", 7, 6);
    mul_check("mul_3_5", 3, 5);
    step();
    got_q.delete();
    send(OP_MUL, 7, 6, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("mul_abort_valid", 32'(bus.out_valid), 32'(0));
    chk("mul_abort_ready", 32'(bus.in_ready),  32'(1));
    step();
    rst_n = 1'b1;
    repeat (W + 2) step();
    chk("mul_abort_noresult", 32'(bus.out_valid), 32'(0));
    chk("mul_abort_nopop",    32'(got_q.size()),  32'(0));
`else
    do1("mul_dis_3_5", OP_MUL, 3, 5, 0);
`endif

    // Exhaustive sweep, then random commands, all under random consumer readiness.
    step();
    got_q.delete();
    exp_q.delete();
    n_sent = 0; n_got = 0; n_extra = 0;
    rand_rdy = 1'b1;
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < M; a++)
        for (int b = 0; b < M; b++)
          for (int ci = 0; ci < 2; ci++) begin
            exp_q.push_back(model(3'(op), a, b, ci));
            send(3'(op), a, b, ci);
            drain_cmp();
          end
    for (int n = 0; n < 300; n++) begin
      int ra, rb, rc;
      logic [2:0] rop;
      rop = 3'($urandom);
      ra  = int'($urandom_range(0, M - 1));
      rb  = int'($urandom_range(0, M - 1));
      rc  = int'($urandom_range(0, 1));
      exp_q.push_back(model(rop, ra, rb, rc));
      send(rop, ra, rb, rc);
      drain_cmp();
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (W + 4) step();
    drain_cmp();
    chk("sb_leftover", 32'(exp_q.size()), 32'(0));
    chk("sb_extra",    32'(n_extra),      32'(0));
    chk("sb_count",    32'(n_got),        32'(n_sent));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arith_alu_seq.md
# arith_alu_seq

Parametrised, registered successor to the 4-bit combinational arithmetic ALU. It is a WIDTH-bit arithmetic unit with a valid/ready handshake on both sides and a one-entry output register. It adds status flags and a multi-cycle shift-add multiply. It sits between the operand/op source (switch decoder or controller) and the result consumer (display or next stage).

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept a command this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry/borrow-in (ADC, SBC only)
- op  input  3  operation select
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result
- c_out  output  1  carry out / multiply high-half-nonzero
- zero  output  1  out == 0
- ovf  output  1  signed two's-complement overflow
- err  output  1  op not supported in this build

## Operation
- Ops:
  - 000 ADD: a+b
  - 001 ADC: a+b+c_in
  - 010 SUB: a+~b+1
  - 011 SBC: a+~b+c_in
  - 100 INC: a+1
  - 101 DEC: a+{WIDTH{1}}
  - 110 MUL: low WIDTH bits of a*b (unsigned)
  - 111 NEG: ~a+1
- Arithmetic is computed in WIDTH+1 bits. out = low WIDTH bits; c_out = bit WIDTH (for SUB/SBC, 1 = no borrow). NEG: c_out=1 iff a==0.
- ovf: set when operands (as applied) share a sign that differs from out's sign. For NEG: ovf=1 iff a==100…0. For MUL: ovf=0.
- MUL: c_out = OR of the high WIDTH bits of the 2·WIDTH product.
- zero is derived from registered out.
- FSM states:
  - IDLE: accepts commands.
  - MUL: iterative multiply, counter WIDTH-1 down to 0, one multiplier bit per cycle.
- Transitions: IDLE→MUL on accepted op 110 (if enabled). MUL→IDLE on the cycle counter==0, loading the output register.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready at a rising edge. Operands are captured at accept; later input changes are ignored.
- Output register: out/c_out/ovf/err hold stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads in the same edge.
- Simultaneous pop and single-cycle accept: the new result loads and out_valid stays 1 (full throughput, one result/cycle).
- During MUL, out_ready may drain the old result. MUL completion blocks nothing, because entry into MUL required the output to be free or draining.

## Timing
- Reset (async assert, sync-released use): state=IDLE, out_valid=0, out=0, c_out=0, ovf=0, err=0, zero=1, counter=0, in_ready=1 after reset.
- Single-cycle ops: accepted at edge k → out_valid=1 with result after edge k (latency 1).
- MUL: accepted at edge k → result after edge k+WIDTH. in_ready=0 for WIDTH cycles.
- rst_n low mid-MUL aborts the multiply; no result is produced.
- No combinational path in→out except in_ready depending on out_ready.

## Configuration
- ARITH_ALU_MUL_EN defined: op 110 runs the shift-add multiply as above.
- ARITH_ALU_MUL_EN undefined: the multiplier and MUL state are removed. Op 110 is single-cycle with out=0, c_out=0, ovf=0, err=1. err is 0 for all other ops in both builds.

## Structure
- Package arith_alu_pkg: op code constants (OP_ADD…OP_NEG) and state encodings (ST_IDLE, ST_MUL).
- Sub-module arith_alu_mul: shift-add datapath (partial product, multiplier shift, counter) with start/done, instantiated only under ARITH_ALU_MUL_EN.
- Adder, flag logic, FSM and output register live in arith_alu_seq.

## Test plan
- WIDTH=4, reset: rst_n=0 → out_valid=0, out=0, zero=1, in_ready=1. ADD a=7 b=9 → out=0, c_out=1, zero=1, ovf=0, one cycle after accept.
- SUB a=3 b=5 → out=14, c_out=0. SBC a=5 b=3 c_in=0 → out=1, c_out=1. ADD a=7 b=1 → out=8, ovf=1.
- NEG a=8 → out=8, ovf=1. NEG a=0 → out=0, c_out=1, zero=1. DEC a=0 → out=15, c_out=0.
- Backpressure: out_ready=0, issue ADD 1+1 then ADD 2+2 → first result (2) held, in_ready=0. Raise out_ready → 2 then 4 delivered, no loss or duplicate.
- MUL (enabled) a=7 b=6 → in_ready low 4 cycles, out=10, c_out=1 at edge k+4. a=3 b=5 → out=15, c_out=0. Reset pulse at cycle 2 of a MUL → no result, state IDLE.
- Macro undefined: op 110 a=3 b=5 → out=0, err=1, latency 1.
- Exhaustive: all a,b,op,c_in combinations at WIDTH=4 compared against a reference model, with random out_ready.
